// File: rtl/lfsr_sym_gen.sv
// lfsr_sym_gen: parametrised Galois LFSR symbol source.
// Each enabled clock advances SYM_BITS LFSR steps (unrolled) and emits one
// SYM_BITS-wide symbol, first generated bit in the MSB. A period-aligned
// symbol index drives period_start/period_end markers.
// Optional build macro: LFSR_PERIOD_CHECK_EN -- keeps a reference copy of the
// seed and flags period_err if the state is not back at the seed when the
// symbol index wraps.

// One Galois step: shift out the MSB, fold the taps back in when it was 1.
module lfsr_galois_step #(
  parameter int                N    = 22,
  parameter logic [N-1:0]      TAPS = '1
) (
  input  logic [N-1:0] i_state,
  output logic [N-1:0] o_state,
  output logic         o_bit
);
  assign o_bit   = i_state[N-1];
  assign o_state = {i_state[N-2:0], 1'b0} ^ (o_bit ? TAPS : '0);
endmodule

module lfsr_sym_gen #(
  parameter int          LFSR_LEN  = 22,
  parameter logic [31:0] TAPS      = 32'h0020_0001,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int          SYM_BITS  = 4,
  parameter int          CYCLE_LEN = 4194303
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_in,
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid,
  output logic [LFSR_LEN-1:0] state_out,
  output logic [LFSR_LEN-1:0] sym_index,
  output logic                period_start,
  output logic                period_end,
  output logic                lockup_err,
  output logic                period_err
);

  localparam logic [LFSR_LEN-1:0] TAPS_N   = TAPS[LFSR_LEN-1:0];
  localparam logic [LFSR_LEN-1:0] SEED_N   = SEED[LFSR_LEN-1:0];
  localparam logic [LFSR_LEN-1:0] LAST_IDX = LFSR_LEN'(CYCLE_LEN - 1);
  localparam logic [LFSR_LEN-1:0] IDX_ONE  = LFSR_LEN'(1);

  logic [LFSR_LEN-1:0] r_state;
  logic [SYM_BITS-1:0] r_sym;
  logic                r_sym_valid;
  logic [LFSR_LEN-1:0] r_sym_index;
  logic                r_lockup_err;

  // w_chain[g] is the state entering step g; w_chain[SYM_BITS] is the result.
  logic [LFSR_LEN-1:0] w_chain [SYM_BITS+1];
  logic [SYM_BITS-1:0] w_sym;
  logic                w_seed_zero;
  logic [LFSR_LEN-1:0] w_load_val;
  logic                w_wrap;

  assign w_chain[0]  = r_state;
  assign w_seed_zero = (seed_in == '0);
  // A zero seed would lock the register at zero forever; fall back to SEED.
  assign w_load_val  = w_seed_zero ? SEED_N : seed_in;
  assign w_wrap      = (r_sym_index == LAST_IDX);

  genvar g;
  generate
    for (g = 0; g < SYM_BITS; g++) begin : g_step
      lfsr_galois_step #(
        .N    (LFSR_LEN),
        .TAPS (TAPS_N)
      ) u_step (
        .i_state (w_chain[g]),
        .o_state (w_chain[g+1]),
        .o_bit   (w_sym[SYM_BITS-1-g])
      );
    end
  endgenerate

  // State, symbol and index update; seed_load outranks clk_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= SEED_N;
      r_sym        <= '0;
      r_sym_valid  <= 1'b0;
      r_sym_index  <= LAST_IDX;
      r_lockup_err <= 1'b0;
    end else if (seed_load) begin
      r_state     <= w_load_val;
      r_sym_index <= LAST_IDX;
      r_sym_valid <= 1'b0;
      if (w_seed_zero) r_lockup_err <= 1'b1;
    end else if (clk_en) begin
      r_state     <= w_chain[SYM_BITS];
      r_sym       <= w_sym;
      r_sym_valid <= 1'b1;
      r_sym_index <= w_wrap ? '0 : r_sym_index + IDX_ONE;
    end else begin
      r_sym_valid <= 1'b0;
    end
  end

`ifdef LFSR_PERIOD_CHECK_EN
  logic [LFSR_LEN-1:0] r_ref_seed;
  logic                r_period_err;

  // Track the seed in force and check the state is back at it on every wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref_seed   <= SEED_N;
      r_period_err <= 1'b0;
    end else if (seed_load) begin
      r_ref_seed <= w_load_val;
    end else if (clk_en && w_wrap && (r_state != r_ref_seed)) begin
      r_period_err <= 1'b1;
    end
  end

  assign period_err = r_period_err;
`else
  assign period_err = 1'b0;
`endif

  assign sym_out      = r_sym;
  assign sym_valid    = r_sym_valid;
  assign state_out    = r_state;
  assign sym_index    = r_sym_index;
  assign lockup_err   = r_lockup_err;
  assign period_start = r_sym_valid && (r_sym_index == '0);
  assign period_end   = r_sym_valid && w_wrap;

endmodule

// File: tb/tb_lfsr_sym_gen.sv
// Bench for lfsr_sym_gen: 4-bit LFSR (x^4+x+1) in three builds -- 1-bit and
// 4-bit symbols with the correct 15-symbol period, and a 1-bit build whose
// period is wrongly set to 14 to exercise the optional period check.
module tb_lfsr_sym_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       seed_load = 1'b0;
  logic [3:0] seed_in = 4'h0;

  logic [0:0] a_sym;  logic a_vld, a_ps, a_pe, a_le, a_pr;  logic [3:0] a_st, a_ix;
  logic [3:0] b_sym;  logic b_vld, b_ps, b_pe, b_le, b_pr;  logic [3:0] b_st, b_ix;
  logic [0:0] c_sym;  logic c_vld, c_ps, c_pe, c_le, c_pr;  logic [3:0] c_st, c_ix;

  int checks = 0;
  int errors = 0;

  // Reference model state, [0] = 1-bit symbols, [1] = 4-bit symbols.
  int m_state [2];
  int m_sym   [2];
  int m_idx   [2];
  int m_valid;
  int m_lock;
  int sbits   [2] = '{1, 4};

  always #5 clk = ~clk;

  lfsr_sym_gen #(.LFSR_LEN(4), .TAPS(32'h3), .SEED(32'h1), .SYM_BITS(1), .CYCLE_LEN(15)) u_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .seed_load(seed_load), .seed_in(seed_in),
    .sym_out(a_sym), .sym_valid(a_vld), .state_out(a_st), .sym_index(a_ix),
    .period_start(a_ps), .period_end(a_pe), .lockup_err(a_le), .period_err(a_pr));

  lfsr_sym_gen #(.LFSR_LEN(4), .TAPS(32'h3), .SEED(32'h1), .SYM_BITS(4), .CYCLE_LEN(15)) u_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .seed_load(seed_load), .seed_in(seed_in),
    .sym_out(b_sym), .sym_valid(b_vld), .state_out(b_st), .sym_index(b_ix),
    .period_start(b_ps), .period_end(b_pe), .lockup_err(b_le), .period_err(b_pr));

  lfsr_sym_gen #(.LFSR_LEN(4), .TAPS(32'h3), .SEED(32'h1), .SYM_BITS(1), .CYCLE_LEN(14)) u_c (
    .clk(clk), .reset(reset), .clk_en(clk_en), .seed_load(seed_load), .seed_in(seed_in),
    .sym_out(c_sym), .sym_valid(c_vld), .state_out(c_st), .sym_index(c_ix),
    .period_start(c_ps), .period_end(c_pe), .lockup_err(c_le), .period_err(c_pr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // x^4+x+1 polynomial: doubling mod 16, folding 3 back in on overflow.
  function automatic int next_state(input int s);
    return ((s * 2) % 16) ^ ((s >= 8) ? 3 : 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 1; m_sym[k] = 0; m_idx[k] = 14;
    end
    m_valid = 0; m_lock = 0;
  endtask

  task automatic model_clock(input logic en, input logic ld, input int sd);
    if (ld) begin
      for (int k = 0; k < 2; k++) begin
        m_state[k] = (sd == 0) ? 1 : sd;
        m_idx[k]   = 14;
      end
      if (sd == 0) m_lock = 1;
      m_valid = 0;
    end else if (en) begin
      for (int k = 0; k < 2; k++) begin
        m_sym[k] = 0;
        for (int j = 0; j < sbits[k]; j++) begin
          m_sym[k]   = m_sym[k] * 2 + m_state[k] / 8;
          m_state[k] = next_state(m_state[k]);
        end
        m_idx[k] = (m_idx[k] + 1) % 15;
      end
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int ps, pe;
      ps = (m_valid != 0 && m_idx[k] == 0)  ? 1 : 0;
      pe = (m_valid != 0 && m_idx[k] == 14) ? 1 : 0;
      if (k == 0) begin
        check("a_sym", 32'(a_sym), m_sym[0]);   check("a_vld", 32'(a_vld), m_valid);
        check("a_state", 32'(a_st), m_state[0]); check("a_idx", 32'(a_ix), m_idx[0]);
        check("a_pstart", 32'(a_ps), ps);        check("a_pend", 32'(a_pe), pe);
        check("a_lock", 32'(a_le), m_lock);      check("a_perr", 32'(a_pr), 0);
      end else begin
        check("b_sym", 32'(b_sym), m_sym[1]);   check("b_vld", 32'(b_vld), m_valid);
        check("b_state", 32'(b_st), m_state[1]); check("b_idx", 32'(b_ix), m_idx[1]);
        check("b_pstart", 32'(b_ps), ps);        check("b_pend", 32'(b_pe), pe);
        check("b_lock", 32'(b_le), m_lock);      check("b_perr", 32'(b_pr), 0);
      end
    end
  endtask

  task automatic cyc(input logic en, input logic ld, input logic [3:0] sd);
    clk_en = en; seed_load = ld; seed_in = sd;
    @(posedge clk);
    model_clock(en, ld, int'(sd));
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("c_perr_rst", 32'(c_pr), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_a_sym [4] = '{0, 0, 0, 1};
  int exp_a_st  [4] = '{2, 4, 8, 3};
  int exp_b_sym [2] = '{1, 3};
  int exp_b_st  [2] = '{3, 5};
  int exp_perr;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("a_pstart_rst", 32'(a_ps), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed: first symbols out of reset, 1 clock latency.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 4'h0);
      check("a_sym_tp", 32'(a_sym), exp_a_sym[i]);
      check("a_state_tp", 32'(a_st), exp_a_st[i]);
      check("a_idx_tp", 32'(a_ix), i);
      check("a_pstart_tp", 32'(a_ps), (i == 0) ? 1 : 0);
      if (i < 2) begin
        check("b_sym_tp", 32'(b_sym), exp_b_sym[i]);
        check("b_state_tp", 32'(b_st), exp_b_st[i]);
      end
    end
    // Complete the period: 15th enable ends it with state back at the seed.
    for (int i = 4; i < 15; i++) cyc(1'b1, 1'b0, 4'h0);
    check("a_pend_15", 32'(a_pe), 1);
    check("a_state_15", 32'(a_st), 1);
    cyc(1'b1, 1'b0, 4'h0);
    check("a_pstart_16", 32'(a_ps), 1);
    check("a_idx_16", 32'(a_ix), 0);
    check("a_sym_16", 32'(a_sym), 0);
`ifdef LFSR_PERIOD_CHECK_EN
    exp_perr = 1;
`else
    exp_perr = 0;
`endif
    check("c_perr_wrap", 32'(c_pr), exp_perr);

    // Idle hold, then load racing an enable.
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'h8);
    check("a_vld_ldwin", 32'(a_vld), 0);
    cyc(1'b1, 1'b0, 4'h0);
    check("a_sym_ld8", 32'(a_sym), 1);
    check("a_state_ld8", 32'(a_st), 3);
    check("a_idx_ld8", 32'(a_ix), 0);

    // Zero seed: fallback to SEED, sticky lockup flag until reset.
    cyc(1'b0, 1'b1, 4'h0);
    check("a_lock_zero", 32'(a_le), 1);
    check("a_state_zero", 32'(a_st), 1);
    cyc(1'b1, 1'b1, 4'h5);
    check("a_lock_sticky", 32'(a_le), 1);
    cyc(1'b1, 1'b0, 4'h0);
    do_reset();
    check("a_lock_clr", 32'(a_le), 0);

    // Randomized traffic against the model, with occasional mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      logic en, ld;
      logic [3:0] sd;
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 24) == 0);
      sd = 4'($urandom_range(0, 15));
      cyc(en, ld, sd);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
